easyaxi_mst_rd: RTL



---
 rtl/easyaxi_pkg.sv | 30 +++
 rtl/easyaxi_mst_rd_if.sv | 32 +++
 rtl/easyaxi_mst_ost_tbl.sv | 77 +++++++
 rtl/easyaxi_mst_rd.sv | 104 ++++++++++
 4 files changed

// File: rtl/easyaxi_pkg.sv
// Shared AXI encodings and width defaults for the EasyAXI bench components.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 16
`endif

package easyaxi_pkg;
   localparam int AXI_LEN_W  = 8;
   localparam int AXI_SIZE_W = 3;

   typedef enum logic [1:0] {
      AXI_RESP_OKAY   = 2'b00,
      AXI_RESP_EXOKAY = 2'b01,
      AXI_RESP_SLVERR = 2'b10,
      AXI_RESP_DECERR = 2'b11
   } axi_resp_e;

   typedef enum logic [1:0] {
      AXI_BURST_FIXED = 2'b00,
      AXI_BURST_INCR  = 2'b01,
      AXI_BURST_WRAP  = 2'b10
   } axi_burst_e;

   // Bit positions inside the sticky error status vector.
   localparam int ERR_RID  = 0;
   localparam int ERR_LAST = 1;
   localparam int ERR_RESP = 2;
endpackage

// File: rtl/easyaxi_mst_rd_if.sv
// AR and R channel bundle between a read master and its slave.
interface easyaxi_mst_rd_if
   import easyaxi_pkg::*;
#(
   parameter int ID_WIDTH   = `AXI_ID_WIDTH,
   parameter int ADDR_WIDTH = `AXI_ADDR_WIDTH,
   parameter int DATA_WIDTH = 32
);
   logic                  arvalid;
   logic                  arready;
   logic [ID_WIDTH-1:0]   arid;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [AXI_LEN_W-1:0]  arlen;
   logic [AXI_SIZE_W-1:0] arsize;
   logic [1:0]            arburst;
   logic                  rvalid;
   logic                  rready;
   logic [ID_WIDTH-1:0]   rid;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rlast;

   modport master (
      output arvalid, arid, araddr, arlen, arsize, arburst, rready,
      input  arready, rvalid, rid, rdata, rresp, rlast
   );

   modport slave (
      input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
      output arready, rvalid, rid, rdata, rresp, rlast
   );
endinterface

// File: rtl/easyaxi_mst_ost_tbl.sv
// Outstanding read burst table: one entry per in-flight ID with its beat count.
module easyaxi_mst_ost_tbl #(
   parameter int ID_WIDTH  = 4,
   parameter int OST_DEPTH = 4,
   parameter int BURST_LEN = 3,
   localparam int IDX_W    = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_alloc,
   input  logic [ID_WIDTH-1:0] i_alloc_id,
   input  logic                i_beat,
   input  logic [ID_WIDTH-1:0] i_beat_id,
   input  logic                i_beat_last,
   output logic                o_hit,
   output logic                o_err_last,
   output logic                o_cmpl,
   output logic [IDX_W-1:0]    o_free_idx,
   output logic                o_full,
   output logic [4:0]          o_ost_cnt
);
   logic [OST_DEPTH-1:0] r_vld;
   logic [ID_WIDTH-1:0]  r_id   [OST_DEPTH];
   logic [3:0]           r_beat [OST_DEPTH];
   logic [4:0]           r_cnt;

   logic             w_match;
   logic [IDX_W-1:0] w_hit_idx;
   logic [IDX_W-1:0] w_free_idx;
   logic             w_at_end;

   // Descending scan so the lowest matching/free index wins.
   always_comb begin
      w_match    = 1'b0;
      w_hit_idx  = '0;
      w_free_idx = '0;
      for (int i = OST_DEPTH - 1; i >= 0; i--) begin
         if (r_vld[i] && (r_id[i] == i_beat_id)) begin
            w_match   = 1'b1;
            w_hit_idx = IDX_W'(i);
         end
         if (!r_vld[i]) w_free_idx = IDX_W'(i);
      end
   end

   assign w_at_end   = (r_beat[w_hit_idx] == 4'(BURST_LEN));
   assign o_hit      = i_beat & w_match;
   assign o_cmpl     = o_hit & (i_beat_last | w_at_end);
   assign o_err_last = o_hit & (i_beat_last ^ w_at_end);
   assign o_free_idx = w_free_idx;
   assign o_full     = (r_cnt == 5'(OST_DEPTH));
   assign o_ost_cnt  = r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
         r_cnt <= '0;
      end else begin
         if (o_cmpl) r_vld[w_hit_idx] <= 1'b0;
         if (i_alloc) r_vld[w_free_idx] <= 1'b1;
         case ({i_alloc, o_cmpl})
            2'b10:   r_cnt <= r_cnt + 5'd1;
            2'b01:   r_cnt <= r_cnt - 5'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Payload is only meaningful while its valid bit is set, so it needs no reset.
   always_ff @(posedge clk) begin
      if (o_hit && !o_cmpl) r_beat[w_hit_idx] <= r_beat[w_hit_idx] + 4'd1;
      if (i_alloc) begin
         r_id[w_free_idx]   <= i_alloc_id;
         r_beat[w_free_idx] <= '0;
      end
   end
endmodule

// File: rtl/easyaxi_mst_rd.sv
// AXI read traffic generator: strided AR issue with incrementing IDs, per-ID R checking.
module easyaxi_mst_rd
   import easyaxi_pkg::*;
#(
   parameter int          ID_WIDTH   = `AXI_ID_WIDTH,
   parameter int          ADDR_WIDTH = `AXI_ADDR_WIDTH,
   parameter int          DATA_WIDTH = 32,
   parameter int          OST_DEPTH  = 4,
   parameter int          BURST_LEN  = 3,
   parameter int unsigned BASE_ADDR  = 0,
   parameter int unsigned ADDR_STEP  = 32'h0010
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   easyaxi_mst_rd_if.master        axi_mst,
   output logic [4:0]              ost_cnt,
   output logic [15:0]             issue_cnt,
   output logic [15:0]             comp_cnt,
   output logic [2:0]              err_sts
);
   localparam int IDX_W = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;

   logic                  r_arvalid;
   logic [ID_WIDTH-1:0]   r_arid;
   logic [ADDR_WIDTH-1:0] r_araddr;
   logic                  r_rready;
   logic [15:0]           r_issue_cnt;
   logic [15:0]           r_comp_cnt;
   logic [2:0]            r_err;

   logic             w_ar_hs;
   logic             w_r_hs;
   logic             w_hit;
   logic             w_err_last;
   logic             w_cmpl;
   logic [IDX_W-1:0] w_free_idx;
   logic             w_full;
   logic             w_unused;

   assign w_ar_hs  = r_arvalid & axi_mst.arready;
   assign w_r_hs   = axi_mst.rvalid & r_rready;
   assign w_unused = ^{axi_mst.rdata, w_free_idx};

   easyaxi_mst_ost_tbl #(
      .ID_WIDTH  (ID_WIDTH),
      .OST_DEPTH (OST_DEPTH),
      .BURST_LEN (BURST_LEN)
   ) u_tbl (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_alloc     (w_ar_hs),
      .i_alloc_id  (r_arid),
      .i_beat      (w_r_hs),
      .i_beat_id   (axi_mst.rid),
      .i_beat_last (axi_mst.rlast),
      .o_hit       (w_hit),
      .o_err_last  (w_err_last),
      .o_cmpl      (w_cmpl),
      .o_free_idx  (w_free_idx),
      .o_full      (w_full),
      .o_ost_cnt   (ost_cnt)
   );

   // arvalid is launched only from registered state, never from arready/enable directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_arvalid   <= 1'b0;
         r_arid      <= '0;
         r_araddr    <= ADDR_WIDTH'(BASE_ADDR);
         r_rready    <= 1'b0;
         r_issue_cnt <= '0;
         r_comp_cnt  <= '0;
         r_err       <= '0;
      end else begin
         r_rready <= 1'b1;
         if (!r_arvalid) begin
            if (enable && !w_full) r_arvalid <= 1'b1;
         end else if (axi_mst.arready) begin
            r_arvalid   <= 1'b0;
            r_arid      <= r_arid + ID_WIDTH'(1);
            r_araddr    <= r_araddr + ADDR_WIDTH'(ADDR_STEP);
            r_issue_cnt <= r_issue_cnt + 16'd1;
         end
         if (w_cmpl) r_comp_cnt <= r_comp_cnt + 16'd1;
         if (w_r_hs) begin
            if (!w_hit)                          r_err[ERR_RID]  <= 1'b1;
            if (w_err_last)                      r_err[ERR_LAST] <= 1'b1;
            if (axi_mst.rresp != AXI_RESP_OKAY)  r_err[ERR_RESP] <= 1'b1;
         end
      end
   end

   assign axi_mst.arvalid = r_arvalid;
   assign axi_mst.arid    = r_arid;
   assign axi_mst.araddr  = r_araddr;
   assign axi_mst.arlen   = AXI_LEN_W'(BURST_LEN);
   assign axi_mst.arsize  = AXI_SIZE_W'($clog2(DATA_WIDTH / 8));
   assign axi_mst.arburst = AXI_BURST_INCR;
   assign axi_mst.rready  = r_rready;
   assign issue_cnt       = r_issue_cnt;
   assign comp_cnt        = r_comp_cnt;
   assign err_sts         = r_err;
endmodule
